// File: rtl/mmio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bus_arbiter
// Description : Round-robin two-master arbiter issuing single-cycle MMIO
//               accesses with registered read data and a one-cycle ack.
//               Optional ownership lock enabled by macro ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
`ifdef ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        gnt,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last_gnt;
    logic   r_owner;
`ifdef ARB_LOCK_EN
    logic   r_locked;
    logic   w_owner_lock;
`endif

    logic              w_any;
    logic              w_pick;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    // Contention goes to the master that did not win last time.
    always_comb begin
        w_any  = m0_req | m1_req;
        w_pick = (m0_req && m1_req) ? ~r_last_gnt : m1_req;
`ifdef ARB_LOCK_EN
        w_owner_lock = r_owner ? m1_lock : m0_lock;
        if (r_locked) begin
            w_any  = r_owner ? m1_req : m0_req;
            w_pick = r_owner;
        end
`endif
        w_sel_wr   = w_pick ? m1_wr      : m0_wr;
        w_sel_addr = w_pick ? m1_addr    : m0_addr;
        w_sel_data = w_pick ? m1_wr_data : m0_wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_gnt   <= 1'b1;
            r_owner      <= 1'b0;
            gnt          <= 2'b00;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            mmio_cs      <= 1'b0;
            mmio_wr      <= 1'b0;
            mmio_rd      <= 1'b0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
            rd_data      <= '0;
`ifdef ARB_LOCK_EN
            r_locked     <= 1'b0;
`endif
        end else begin
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            mmio_cs <= 1'b0;
            mmio_wr <= 1'b0;
            mmio_rd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner      <= w_pick;
                        mmio_addr    <= w_sel_addr;
                        mmio_wr_data <= w_sel_data;
                        mmio_cs      <= 1'b1;
                        mmio_wr      <= w_sel_wr;
                        mmio_rd      <= ~w_sel_wr;
                        gnt          <= w_pick ? 2'b10 : 2'b01;
                        r_state      <= ST_ISSUE;
                    end
`ifdef ARB_LOCK_EN
                    else if (r_locked && !w_owner_lock) begin
                        r_locked   <= 1'b0;
                        gnt        <= 2'b00;
                        r_last_gnt <= r_owner;
                    end
`endif
                end
                ST_ISSUE: begin
                    if (mmio_rd) begin
                        rd_data <= mmio_rd_data;
                    end
                    if (r_owner) begin
                        m1_ack <= 1'b1;
                    end else begin
                        m0_ack <= 1'b1;
                    end
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
`ifdef ARB_LOCK_EN
                    if (w_owner_lock) begin
                        r_locked <= 1'b1;
                    end else begin
                        r_locked   <= 1'b0;
                        gnt        <= 2'b00;
                        r_last_gnt <= r_owner;
                    end
`else
                    gnt        <= 2'b00;
                    r_last_gnt <= r_owner;
`endif
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
